// File: rtl/nes_i2c_target_pkg.sv
// -----------------------------------------------------------------------------
// nes_i2c_target_pkg
// Shared definitions for the NES classic-controller I2C target.
//   - NES_I2C_ADDR      : 7-bit bus address of the accessory (0x52)
//   - RW_WRITE/RW_READ  : value of the R/W bit in the address byte
//   - REPORT_LEN        : number of real report bytes; pointers at or above it
//                         read back as 8'hFF
//   - B4_POS_* / B5_POS_*: bit position of each joypad bit inside report
//                         bytes 4 and 5. The bridge unpacks with these same
//                         constants, so packing and unpacking cannot diverge.
//   - tgt_state_e       : target protocol state
//   - report_byte()     : report byte selected by the register pointer
// -----------------------------------------------------------------------------
package nes_i2c_target_pkg;

  localparam logic [6:0] NES_I2C_ADDR = 7'h52;
  localparam logic       RW_WRITE     = 1'b0;
  localparam logic       RW_READ      = 1'b1;
  localparam int         REPORT_LEN   = 6;

  // Report byte 4 = {j[0], j[2], 0, j[5], 0, j[4], 0, 0}
  localparam int B4_POS_J0 = 7;
  localparam int B4_POS_J2 = 6;
  localparam int B4_POS_J5 = 4;
  localparam int B4_POS_J4 = 2;

  // Report byte 5 = {0, j[6], 0, j[7], 0, 0, j[1], j[3]}
  localparam int B5_POS_J6 = 6;
  localparam int B5_POS_J7 = 4;
  localparam int B5_POS_J1 = 1;
  localparam int B5_POS_J3 = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } tgt_state_e;

  function automatic logic [7:0] report_byte(input logic [2:0] p, input logic [7:0] j);
    logic [7:0] b;
    // NOTE: give every bit a value before the branches so no path leaves b unassigned.
    b = 8'h00;
    if (p == 3'd4) begin
      b[B4_POS_J0] = j[0];
      b[B4_POS_J2] = j[2];
      b[B4_POS_J5] = j[5];
      b[B4_POS_J4] = j[4];
    end else if (p == 3'd5) begin
      b[B5_POS_J6] = j[6];
      b[B5_POS_J7] = j[7];
      b[B5_POS_J1] = j[1];
      b[B5_POS_J3] = j[3];
    end else if (int'(p) >= REPORT_LEN) begin
      b = 8'hFF;
    end
    return b;
  endfunction

endpackage

// File: rtl/nes_i2c_target_i2c_line_sync.sv
// -----------------------------------------------------------------------------
// nes_i2c_target_i2c_line_sync
// Brings raw SCL/SDA into the clk domain and produces level/edge/bus-condition
// pulses for the target FSM.
//   clk, rst_n  : system clock, async active-low reset
//   i_scl/i_sda : raw bus lines, asynchronous to clk
//   o_sda       : conditioned SDA level
//   o_scl_rise  : one-cycle pulse on conditioned SCL rising edge
//   o_scl_fall  : one-cycle pulse on conditioned SCL falling edge
//   o_start     : SDA falling while SCL high (START / repeated START)
//   o_stop      : SDA rising while SCL high (STOP)
// Optional glitch filter: define NES_I2C_TARGET_FILTER_EN; a level is then
// accepted only after FILTER_LEN consecutive equal synchronized samples.
// -----------------------------------------------------------------------------
module nes_i2c_target_i2c_line_sync
`ifdef NES_I2C_TARGET_FILTER_EN
#(
  parameter int unsigned FILTER_LEN = 4
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic       w_scl_lvl;
  logic       w_sda_lvl;

  // Synchronizers reset to the idle-bus level (high) so leaving reset does not
  // look like an edge or a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
    end
  end

`ifdef NES_I2C_TARGET_FILTER_EN
  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    w_sync_lvl;  // [0] = SCL, [1] = SDA
  logic [1:0]    r_filt;
  logic [CW-1:0] r_cnt [2];

  assign w_sync_lvl = {r_sda_sync[1], r_scl_sync[1]};

  // r_cnt counts consecutive samples that disagree with the accepted level;
  // the FILTER_LEN-th disagreeing sample in a row flips the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 2'b11;
      // NOTE: the two-entry counter array is small control state, so it is reset like any other flop.
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_sync_lvl[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
          r_filt[i] <= w_sync_lvl[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_scl_lvl = r_filt[0];
  assign w_sda_lvl = r_filt[1];
`else
  assign w_scl_lvl = r_scl_sync[1];
  assign w_sda_lvl = r_sda_sync[1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= w_scl_lvl;
      r_sda_prev <= w_sda_lvl;
    end
  end

  assign o_sda      = w_sda_lvl;
  assign o_scl_rise = w_scl_lvl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl_lvl & r_scl_prev;
  // SCL must be high on both sides of the SDA edge to count as a bus condition.
  assign o_start    = ~w_sda_lvl & r_sda_prev & w_scl_lvl & r_scl_prev;
  assign o_stop     = w_sda_lvl & ~r_sda_prev & w_scl_lvl & r_scl_prev;

endmodule

// File: rtl/nes_i2c_target.sv
// -----------------------------------------------------------------------------
// nes_i2c_target
// I2C target emulating the NES classic-controller accessory. A one-byte write
// sets a 3-bit register pointer; reads return a 6-byte report built from a
// joypad snapshot taken at read-address match.
//   clk, rst_n : system clock, async active-low reset
//   scl_in     : raw SCL (async)
//   sda_in     : raw SDA (async)
//   sda_oe     : 1 = pull SDA low, 0 = release (only SDA driver)
//   joypad     : live button state, active-high
//   busy       : high from address ACK until STOP or repeated START
//   ptr        : current register pointer
//   rd_done    : one-cycle pulse when the master NACKs a read byte
// Optional glitch filter on SCL/SDA: define NES_I2C_TARGET_FILTER_EN.
// -----------------------------------------------------------------------------
module nes_i2c_target
  import nes_i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = NES_I2C_ADDR,
  parameter int unsigned HOLD_CYCLES = 8
`ifdef NES_I2C_TARGET_FILTER_EN
  ,
  parameter int unsigned FILTER_LEN  = 4
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] joypad,
  output logic       busy,
  output logic [2:0] ptr,
  output logic       rd_done
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  logic          w_sda;
  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;

  tgt_state_e    r_state;
  logic          r_sda_oe;
  logic          r_busy;
  logic [2:0]    r_ptr;
  logic          r_rd_done;
  logic [6:0]    r_shift;
  logic [3:0]    r_bit_ctr;
  logic [7:0]    r_snap;
  logic          r_rw;
  logic          r_ack_on;   // ACK currently driven in ADDR_ACK/WR_ACK
  logic [HW-1:0] r_hold_cnt;

  logic [7:0]    w_rx_byte;
  logic [7:0]    w_tx_byte;
  logic          w_tx_bit;
  logic          w_hold_fire;
  logic          w_hold_arm;

  nes_i2c_target_i2c_line_sync
`ifdef NES_I2C_TARGET_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
    u_line_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_scl      (scl_in),
      .i_sda      (sda_in),
      .o_sda      (w_sda),
      .o_scl_rise (w_scl_rise),
      .o_scl_fall (w_scl_fall),
      .o_start    (w_start),
      .o_stop     (w_stop)
    );

  assign w_rx_byte   = {r_shift, w_sda};
  assign w_tx_byte   = report_byte(r_ptr, r_snap);
  // r_bit_ctr counts bits already driven, so 7 - ctr (= ~ctr on 3 bits) is next.
  assign w_tx_bit    = w_tx_byte[~r_bit_ctr[2:0]];
  assign w_hold_fire = (r_hold_cnt == HW'(1));
  // Only states that change SDA on the low phase time the data hold.
  assign w_hold_arm  = (r_state == ST_ADDR_ACK) || (r_state == ST_WR_ACK) ||
                       (r_state == ST_RD_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_ptr      <= 3'd0;
      r_rd_done  <= 1'b0;
      r_shift    <= 7'd0;
      r_bit_ctr  <= 4'd0;
      r_snap     <= 8'd0;
      r_rw       <= RW_WRITE;
      r_ack_on   <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_rd_done <= 1'b0;
      if (w_start) begin
        r_state    <= ST_ADDR;
        r_bit_ctr  <= 4'd0;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_ack_on   <= 1'b0;
        r_hold_cnt <= '0;
      end else if (w_stop) begin
        r_state    <= ST_IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_ack_on   <= 1'b0;
        r_hold_cnt <= '0;
      end else begin
        if (w_scl_fall && w_hold_arm) begin
          r_hold_cnt <= HW'(HOLD_CYCLES);
        end else if (r_hold_cnt != '0) begin
          r_hold_cnt <= r_hold_cnt - 1'b1;
        end

        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte[6:0];
              if (r_bit_ctr == 4'd7) begin
                r_bit_ctr <= 4'd0;
                r_rw      <= w_sda;
                if (w_rx_byte[7:1] == TARGET_ADDR) begin
                  r_state <= ST_ADDR_ACK;
                  if (w_sda == RW_READ) r_snap <= joypad;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end else begin
                r_bit_ctr <= r_bit_ctr + 4'd1;
              end
            end
          end

          ST_ADDR_ACK, ST_WR_ACK: begin
            if (w_hold_fire) begin
              if (!r_ack_on) begin
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_ack_on <= 1'b1;
              end else begin
                r_ack_on <= 1'b0;
                if (r_rw == RW_READ) begin
                  // The ACK release fall also carries the first data bit.
                  r_sda_oe  <= ~w_tx_bit;
                  r_bit_ctr <= 4'd1;
                  r_state   <= ST_RD_DATA;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_bit_ctr <= 4'd0;
                  r_state   <= ST_WR_DATA;
                end
              end
            end
          end

          ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= w_rx_byte[6:0];
              if (r_bit_ctr == 4'd7) begin
                r_bit_ctr <= 4'd0;
                r_ptr     <= w_rx_byte[2:0];
                r_state   <= ST_WR_ACK;
              end else begin
                r_bit_ctr <= r_bit_ctr + 4'd1;
              end
            end
          end

          ST_RD_DATA: begin
            if (w_hold_fire) begin
              if (r_bit_ctr == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_ctr <= 4'd0;
                r_state   <= ST_RD_ACK;
              end else begin
                r_sda_oe  <= ~w_tx_bit;
                r_bit_ctr <= r_bit_ctr + 4'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (w_scl_rise) begin
              r_ptr <= r_ptr + 3'd1;
              if (w_sda) begin
                r_rd_done <= 1'b1;
                r_state   <= ST_IGNORE;
              end else begin
                r_bit_ctr <= 4'd0;
                r_state   <= ST_RD_DATA;
              end
            end
          end

          ST_IDLE, ST_IGNORE: begin
            r_sda_oe <= 1'b0;
          end

          default: begin
            r_state  <= ST_IDLE;
            r_sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe  = r_sda_oe;
  assign busy    = r_busy;
  assign ptr     = r_ptr;
  assign rd_done = r_rd_done;

endmodule
